// File: rtl/exu_agu_amo_seq.sv
// exu_agu_amo_seq: multi-cycle AMO sequencer on the AGU side of the shared ALU datapath.
// Ports: i_* issue handshake from EXU dispatch; agu_req_alu* datapath request with
// same-cycle agu_req_alu_res; agu_sbf_* shared buffer 0 (old value) / 1 (new value);
// cmd_*/rsp_* LSU bus; o_wbck_* register writeback; busy when not idle.
module exu_agu_amo_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_valid,
   output logic            i_ready,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [4:0]      i_rdidx,
   input  logic [3:0]      i_amo_op,
   output logic            agu_req_alu,
   output logic [XLEN-1:0] agu_req_alu_op1,
   output logic [XLEN-1:0] agu_req_alu_op2,
   output logic            agu_req_alu_swap,
   output logic            agu_req_alu_add,
   output logic            agu_req_alu_and,
   output logic            agu_req_alu_or,
   output logic            agu_req_alu_xor,
   output logic            agu_req_alu_max,
   output logic            agu_req_alu_min,
   output logic            agu_req_alu_maxu,
   output logic            agu_req_alu_minu,
   input  logic [XLEN-1:0] agu_req_alu_res,
   output logic            agu_sbf_0_ena,
   output logic [XLEN-1:0] agu_sbf_0_nxt,
   input  logic [XLEN-1:0] agu_sbf_0_r,
   output logic            agu_sbf_1_ena,
   output logic [XLEN-1:0] agu_sbf_1_nxt,
   input  logic [XLEN-1:0] agu_sbf_1_r,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output logic            cmd_read,
   output logic [XLEN-1:0] cmd_addr,
   output logic [XLEN-1:0] cmd_wdata,
   output logic [3:0]      cmd_wmask,
   input  logic            rsp_valid,
   output logic            rsp_ready,
   input  logic [XLEN-1:0] rsp_rdata,
   input  logic            rsp_err,
   output logic            o_wbck_valid,
   input  logic            o_wbck_ready,
   output logic [XLEN-1:0] o_wbck_wdat,
   output logic [4:0]      o_wbck_rdidx,
   output logic            o_wbck_err,
   output logic            o_wbck_misalgn,
   output logic            busy
);
   typedef enum logic [2:0] {IDLE, RD_CMD, RD_RSP, ALU, WR_CMD, WR_RSP, WBCK} state_t;
   state_t          state;
   logic [XLEN-1:0] rs1_r, rs2_r;
   logic [4:0]      rdidx_r;
   logic [3:0]      op_r;
   logic            err_r, misalgn_r;
   logic            is_alu, is_rd_cmd, is_wr_cmd, is_rsp;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         rs1_r     <= '0;
         rs2_r     <= '0;
         rdidx_r   <= '0;
         op_r      <= '0;
         err_r     <= 1'b0;
         misalgn_r <= 1'b0;
      end else
         case (state)
            IDLE: if (i_valid) begin
               rs1_r     <= i_rs1;
               rs2_r     <= i_rs2;
               rdidx_r   <= i_rdidx;
               op_r      <= i_amo_op;
               err_r     <= 1'b0;
               misalgn_r <= |i_rs1[1:0];
               state     <= |i_rs1[1:0] ? WBCK : RD_CMD;
            end
            RD_CMD: if (cmd_ready) state <= RD_RSP;
            RD_RSP: if (rsp_valid) begin
               err_r <= rsp_err;
               state <= rsp_err ? WBCK : ALU;
            end
            ALU:    state <= WR_CMD;
            WR_CMD: if (cmd_ready) state <= WR_RSP;
            WR_RSP: if (rsp_valid) begin
               err_r <= rsp_err;
               state <= WBCK;
            end
            WBCK: if (o_wbck_ready) begin
               misalgn_r <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
   assign is_alu    = state == ALU;
   assign is_rd_cmd = state == RD_CMD;
   assign is_wr_cmd = state == WR_CMD;
   assign is_rsp    = state == RD_RSP || state == WR_RSP;
   assign i_ready   = state == IDLE;
   assign busy      = state != IDLE;
   // Reserved opcodes 9-15 fall back to swap.
   assign agu_req_alu      = is_alu;
   assign agu_req_alu_op1  = is_alu ? agu_sbf_0_r : '0;
   assign agu_req_alu_op2  = is_alu ? rs2_r : '0;
   assign agu_req_alu_swap = is_alu && (op_r == 4'd0 || op_r > 4'd8);
   assign agu_req_alu_add  = is_alu && op_r == 4'd1;
   assign agu_req_alu_xor  = is_alu && op_r == 4'd2;
   assign agu_req_alu_and  = is_alu && op_r == 4'd3;
   assign agu_req_alu_or   = is_alu && op_r == 4'd4;
   assign agu_req_alu_min  = is_alu && op_r == 4'd5;
   assign agu_req_alu_max  = is_alu && op_r == 4'd6;
   assign agu_req_alu_minu = is_alu && op_r == 4'd7;
   assign agu_req_alu_maxu = is_alu && op_r == 4'd8;
   assign agu_sbf_0_ena = state == RD_RSP && rsp_valid;
   assign agu_sbf_0_nxt = rsp_rdata;
   assign agu_sbf_1_ena = is_alu;
   assign agu_sbf_1_nxt = agu_req_alu_res;
   assign cmd_valid = is_rd_cmd || is_wr_cmd;
   assign cmd_read  = is_rd_cmd;
   assign cmd_addr  = cmd_valid ? rs1_r : '0;
   assign cmd_wdata = is_wr_cmd ? agu_sbf_1_r : '0;
   assign cmd_wmask = cmd_valid ? 4'hF : 4'h0;
   assign rsp_ready = is_rsp;
   assign o_wbck_valid   = state == WBCK;
   assign o_wbck_wdat    = (state == WBCK && !misalgn_r) ? agu_sbf_0_r : '0;
   assign o_wbck_rdidx   = rdidx_r;
   assign o_wbck_err     = err_r;
   assign o_wbck_misalgn = misalgn_r;
endmodule

// File: tb/tb_exu_agu_amo_seq.sv
// tb_exu_agu_amo_seq: randomized self-checking bench against an AMO reference model.
module tb_exu_agu_amo_seq;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        i_valid = 1'b0, i_ready;
   logic [31:0] i_rs1 = '0, i_rs2 = '0;
   logic [4:0]  i_rdidx = '0;
   logic [3:0]  i_amo_op = '0;
   logic        agu_req_alu;
   logic [31:0] agu_req_alu_op1, agu_req_alu_op2, agu_req_alu_res;
   logic        f_swap, f_add, f_and, f_or, f_xor, f_max, f_min, f_maxu, f_minu;
   logic        agu_sbf_0_ena, agu_sbf_1_ena;
   logic [31:0] agu_sbf_0_nxt, agu_sbf_1_nxt;
   logic [31:0] sbf0 = '0, sbf1 = '0;
   logic        cmd_valid, cmd_ready = 1'b0, cmd_read;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wmask;
   logic        rsp_valid = 1'b0, rsp_ready, rsp_err = 1'b0;
   logic [31:0] rsp_rdata = '0;
   logic        o_wbck_valid, o_wbck_ready = 1'b0, o_wbck_err, o_wbck_misalgn, busy;
   logic [31:0] o_wbck_wdat;
   logic [4:0]  o_wbck_rdidx;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   exu_agu_amo_seq #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rdidx(i_rdidx), .i_amo_op(i_amo_op),
      .agu_req_alu(agu_req_alu), .agu_req_alu_op1(agu_req_alu_op1), .agu_req_alu_op2(agu_req_alu_op2),
      .agu_req_alu_swap(f_swap), .agu_req_alu_add(f_add), .agu_req_alu_and(f_and),
      .agu_req_alu_or(f_or), .agu_req_alu_xor(f_xor), .agu_req_alu_max(f_max),
      .agu_req_alu_min(f_min), .agu_req_alu_maxu(f_maxu), .agu_req_alu_minu(f_minu),
      .agu_req_alu_res(agu_req_alu_res),
      .agu_sbf_0_ena(agu_sbf_0_ena), .agu_sbf_0_nxt(agu_sbf_0_nxt), .agu_sbf_0_r(sbf0),
      .agu_sbf_1_ena(agu_sbf_1_ena), .agu_sbf_1_nxt(agu_sbf_1_nxt), .agu_sbf_1_r(sbf1),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .o_wbck_valid(o_wbck_valid), .o_wbck_ready(o_wbck_ready), .o_wbck_wdat(o_wbck_wdat),
      .o_wbck_rdidx(o_wbck_rdidx), .o_wbck_err(o_wbck_err), .o_wbck_misalgn(o_wbck_misalgn),
      .busy(busy)
   );

   // shared buffers and shared ALU datapath that live outside the sequencer
   always_ff @(posedge clk) begin
      if (agu_sbf_0_ena) sbf0 <= agu_sbf_0_nxt;
      if (agu_sbf_1_ena) sbf1 <= agu_sbf_1_nxt;
   end
   always_comb begin
      agu_req_alu_res = 32'h0;
      if (f_swap) agu_req_alu_res = agu_req_alu_op2;
      if (f_add)  agu_req_alu_res = agu_req_alu_op1 + agu_req_alu_op2;
      if (f_and)  agu_req_alu_res = agu_req_alu_op1 & agu_req_alu_op2;
      if (f_or)   agu_req_alu_res = agu_req_alu_op1 | agu_req_alu_op2;
      if (f_xor)  agu_req_alu_res = agu_req_alu_op1 ^ agu_req_alu_op2;
      if (f_max)  agu_req_alu_res = $signed(agu_req_alu_op1) > $signed(agu_req_alu_op2) ? agu_req_alu_op1 : agu_req_alu_op2;
      if (f_min)  agu_req_alu_res = $signed(agu_req_alu_op1) < $signed(agu_req_alu_op2) ? agu_req_alu_op1 : agu_req_alu_op2;
      if (f_maxu) agu_req_alu_res = agu_req_alu_op1 > agu_req_alu_op2 ? agu_req_alu_op1 : agu_req_alu_op2;
      if (f_minu) agu_req_alu_res = agu_req_alu_op1 < agu_req_alu_op2 ? agu_req_alu_op1 : agu_req_alu_op2;
   end

   function automatic logic [31:0] amo_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd1: return a + b;
         4'd2: return a ^ b;
         4'd3: return a & b;
         4'd4: return a | b;
         4'd5: return $signed(a) < $signed(b) ? a : b;
         4'd6: return $signed(a) > $signed(b) ? a : b;
         4'd7: return a < b ? a : b;
         4'd8: return a > b ? a : b;
         default: return b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_amo(input logic [31:0] addr, input logic [31:0] rs2v, input logic [31:0] memv,
                         input logic [4:0] rd, input logic [3:0] op, input int rd_stall, input int wr_stall,
                         input bit rd_err, input bit wr_err, input bit abort_wr);
      logic [31:0] exp_w, hold_addr, hold_wd;
      bit mis, pend, done, wrote, read_seen, rsp_is_rd, holding;
      int lat, stall, seen_lat, exp_lat;
      mis = addr[1:0] != 2'b00;
      exp_w = amo_ref(op, memv, rs2v);
      exp_lat = mis ? 1 : rd_err ? 3 + rd_stall : 6 + rd_stall + wr_stall;
      {pend, done, wrote, read_seen, rsp_is_rd, holding} = '0;
      stall = 0; seen_lat = 0; hold_addr = '0; hold_wd = '0;
      @(negedge clk);
      chk("i_ready_idle", i_ready, 1);
      i_valid = 1'b1; i_rs1 = addr; i_rs2 = rs2v; i_rdidx = rd; i_amo_op = op;
      @(posedge clk);
      #1 i_valid = 1'b0; i_rs1 = $urandom; i_rs2 = $urandom; i_rdidx = 5'($urandom); i_amo_op = 4'($urandom);
      lat = 1;
      for (int c = 0; c < 80 && !done; c++) begin
         @(negedge clk);
         cmd_ready = 1'b0; o_wbck_ready = 1'b0; rsp_rdata = $urandom;
         rsp_valid = rsp_ready ? 1'b0 : 1'($urandom_range(0, 1));
         rsp_err = !rsp_ready;
         if (o_wbck_valid) begin
            if (seen_lat == 0) begin
               seen_lat = lat;
               chk("wbck_lat", lat, exp_lat);
               chk("wbck_wdat", o_wbck_wdat, mis ? 32'h0 : memv);
               chk("wbck_err", o_wbck_err, !mis && (rd_err || wr_err));
               chk("wbck_misalgn", o_wbck_misalgn, mis);
               chk("wbck_rdidx", o_wbck_rdidx, rd);
               chk("read_issued", read_seen, !mis);
               chk("write_issued", wrote, !mis && !rd_err);
            end
            chk("i_ready_wbck", i_ready, 0);
            o_wbck_ready = 1'($urandom_range(0, 1));
            done = o_wbck_ready;
         end else begin
            chk("i_ready_busy", {i_ready, busy}, 2'b01);
            if (cmd_valid) begin
               if (holding) begin
                  chk("cmd_addr_stable", cmd_addr, hold_addr);
                  chk("cmd_wdata_stable", cmd_wdata, hold_wd);
               end else begin
                  holding = 1; hold_addr = cmd_addr; hold_wd = cmd_wdata;
                  chk("cmd_addr", cmd_addr, addr);
                  chk("cmd_wmask", cmd_wmask, 4'hF);
                  if (cmd_read) read_seen = 1;
                  else begin
                     wrote = 1;
                     chk("cmd_wdata", cmd_wdata, exp_w);
                     if (abort_wr) begin
                        rst_n = 1'b0;
                        #1;
                        chk("abort_cmd_valid", cmd_valid, 0);
                        chk("abort_idle", {i_ready, busy, o_wbck_valid}, 3'b100);
                        @(negedge clk);
                        rst_n = 1'b1;
                        rsp_valid = 1'b0;
                        return;
                     end
                  end
                  stall = cmd_read ? rd_stall : wr_stall;
               end
               if (stall > 0) stall--;
               else begin
                  cmd_ready = 1'b1; holding = 0; pend = 1; rsp_is_rd = cmd_read;
               end
            end else if (rsp_ready && pend) begin
               rsp_valid = 1'b1;
               rsp_rdata = rsp_is_rd ? memv : $urandom;
               rsp_err = rsp_is_rd ? rd_err : wr_err;
               pend = 0;
            end
            if (agu_req_alu) begin
               chk("alu_onehot", $countones({f_swap, f_add, f_and, f_or, f_xor, f_max, f_min, f_maxu, f_minu}), 1);
               chk("alu_op1", agu_req_alu_op1, memv);
               chk("alu_op2", agu_req_alu_op2, rs2v);
            end else
               chk("alu_quiet", {f_swap, f_add, f_and, f_or, f_xor, f_max, f_min, f_maxu, f_minu,
                                 |agu_req_alu_op1, |agu_req_alu_op2}, 0);
         end
         @(posedge clk);
         lat++;
      end
      chk("amo_done", done, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", {i_ready, busy}, 2'b10);
      chk("rst_outs", {cmd_valid, rsp_ready, o_wbck_valid, agu_req_alu, agu_sbf_0_ena, agu_sbf_1_ena}, 0);
      rst_n = 1'b1;
      do_amo(32'h100, 32'h1, 32'hFFFFFFFF, 5'd5, 4'd1, 0, 0, 0, 0, 0);
      do_amo(32'h200, 32'h1, 32'h80000000, 5'd6, 4'd6, 0, 0, 0, 0, 0);
      do_amo(32'h204, 32'h1, 32'h80000000, 5'd7, 4'd8, 0, 0, 0, 0, 0);
      do_amo(32'h300, 32'hDEADBEEF, 32'h12345678, 5'd8, 4'd0, 3, 3, 0, 0, 0);
      do_amo(32'h102, 32'h5, 32'hCAFEF00D, 5'd9, 4'd1, 0, 0, 0, 0, 0);
      do_amo(32'h400, 32'h7, 32'h0BADF00D, 5'd10, 4'd4, 0, 0, 1, 0, 0);
      do_amo(32'h404, 32'h7, 32'h600DF00D, 5'd11, 4'd2, 0, 0, 0, 1, 0);
      do_amo(32'h500, 32'h3, 32'h11111111, 5'd12, 4'd1, 0, 2, 0, 0, 1);
      do_amo(32'h504, 32'h3, 32'h22222222, 5'd0, 4'd1, 0, 0, 0, 0, 0);
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = {$urandom} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         do_amo(a, $urandom, $urandom, 5'($urandom), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/exu_agu_amo_seq.md
Name: exu_agu_amo_seq

Overview:
- Multi-cycle AMO sequencer in the EXU that acts as the requester on the AGU side of the shared ALU datapath.
- Per accepted AMO it reads memory over a cmd/rsp bus and holds the old value in shared buffer 0.
- It then drives one AGU datapath request to combine old value and rs2, holds the result in shared buffer 1, writes it back to memory, and returns the old value for register writeback.
- Sits between EXU dispatch, the ALU datapath AGU port and the LSU bus.

Parameters:
- XLEN, 32, data/address width; must equal the core XLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  AMO issue valid
- i_ready  out  1  sequencer can accept
- i_rs1  in  XLEN  AMO address
- i_rs2  in  XLEN  AMO operand
- i_rdidx  in  5  destination register
- i_amo_op  in  4  0 swap, 1 add, 2 xor, 3 and, 4 or, 5 min, 6 max, 7 minu, 8 maxu, 9-15 reserved (treated as swap)
- agu_req_alu  out  1  datapath request
- agu_req_alu_op1/op2  out  XLEN  datapath operands
- agu_req_alu_swap/add/and/or/xor/max/min/maxu/minu  out  1 each  one-hot op select
- agu_req_alu_res  in  XLEN  datapath result, same cycle
- agu_sbf_0_ena/agu_sbf_1_ena  out  1  shared buffer write enables
- agu_sbf_0_nxt/agu_sbf_1_nxt  out  XLEN  shared buffer next values
- agu_sbf_0_r/agu_sbf_1_r  in  XLEN  shared buffer contents
- cmd_valid  out  1  bus command valid
- cmd_ready  in  1  bus command ready
- cmd_read  out  1  1 read, 0 write
- cmd_addr  out  XLEN  command address
- cmd_wdata  out  XLEN  write data
- cmd_wmask  out  4  byte mask
- rsp_valid  in  1  bus response valid
- rsp_ready  out  1  bus response ready
- rsp_rdata  in  XLEN  read data
- rsp_err  in  1  bus error
- o_wbck_valid  out  1  writeback valid
- o_wbck_ready  in  1  writeback ready
- o_wbck_wdat  out  XLEN  old memory value
- o_wbck_rdidx  out  5  destination register
- o_wbck_err  out  1  bus error occurred
- o_wbck_misalgn  out  1  address misaligned
- busy  out  1  state != IDLE

Behaviour:
- Single clock, clk. rst_n is asynchronous, active-low.
- On reset: state=IDLE; latched rs1, rs2, rdidx, op, err and misalgn registers cleared to 0.
- All outputs are combinational from state/registers. After reset: i_ready=1; all valid/ena/agu_req outputs 0; busy=0.
- Reset asserted in any state aborts immediately to IDLE. An outstanding bus command is dropped; no writeback is issued.

State machine (one-hot or encoded; transitions only on rising clk):
- IDLE:
  - i_ready=1.
  - On i_valid: latch rs1, rs2, rdidx, op; clear err.
  - If i_rs1[1:0]!=0: set misalgn=1 and go to WBCK.
  - Otherwise go to RD_CMD.
- RD_CMD:
  - cmd_valid=1, cmd_read=1, cmd_addr=rs1_r, cmd_wmask=4'hF.
  - Hold until cmd_ready, then go to RD_RSP.
- RD_RSP:
  - rsp_ready=1.
  - On rsp_valid: agu_sbf_0_ena=1, agu_sbf_0_nxt=rsp_rdata.
  - If rsp_err: set err, go to WBCK (no write).
  - Otherwise go to ALU.
- ALU (exactly 1 cycle):
  - agu_req_alu=1, op1=agu_sbf_0_r, op2=rs2_r; exactly one op flag high per op_r.
  - agu_sbf_1_ena=1, agu_sbf_1_nxt=agu_req_alu_res.
  - Go to WR_CMD.
- WR_CMD:
  - cmd_valid=1, cmd_read=0, addr=rs1_r, wdata=agu_sbf_1_r, wmask=4'hF.
  - On cmd_ready, go to WR_RSP.
- WR_RSP:
  - rsp_ready=1.
  - On rsp_valid: err<=rsp_err; go to WBCK.
- WBCK:
  - o_wbck_valid=1, wdat=agu_sbf_0_r (0 if misalgn), rdidx=rdidx_r, err/misalgn from registers.
  - On o_wbck_ready, go to IDLE. Also clear misalgn.

Interface rules:
- Outside ALU: agu_req_alu, all op flags and op1/op2 are 0.
- Outside RD_CMD/WR_CMD: cmd_valid=0 and cmd_* are 0.
- rsp_ready=0 outside RD_RSP/WR_RSP; rsp_valid arriving then is ignored.
- cmd_valid and its payload stay stable while stalled.
- rdidx=0 is still presented on writeback.
- No new issue is accepted before WBCK completes; i_ready is 0 in all non-IDLE states.
- Minimum latency, zero stall, accept to wbck valid: 6 cycles. Misaligned: 1 cycle.

Test Plan:
- amoadd: rs1=0x100, mem=0xFFFFFFFF, rs2=1, all readies 1 -> write 0x00000000 to 0x100; wbck wdat=0xFFFFFFFF, err=0, 6 cycles from accept.
- amomax vs amomaxu: mem=0x80000000, rs2=0x00000001 -> max writes 0x00000001; maxu writes 0x80000000; wdat=0x80000000 for both.
- amoswap with cmd_ready low 3 cycles in RD_CMD and WR_CMD -> cmd_valid/addr/wdata stable; write 0xDEADBEEF (rs2); i_ready stays 0.
- Misaligned rs1=0x102 -> no cmd_valid; next cycle wbck valid, misalgn=1, wdat=0.
- Read rsp_err=1 -> no write command; wbck err=1. Write rsp_err=1 -> wbck err=1, wdat=old value.
- rst_n low during WR_CMD -> cmd_valid drops asynchronously, state IDLE, i_ready=1; next AMO completes normally.
